// File: rtl/core_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_host_seq : preloads operands, pulses core reset, runs the core with a
//                 timeout, then drains results. Optional: HOST_CHECKSUM_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module core_host_seq #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOAD_N   = 64,
  parameter int RES_BASE = 64,
  parameter int RES_N    = 32,
  parameter int TIMEOUT  = 4096,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_dat,
  input  logic [DW-1:0] mem_rd_dat,
  output logic          core_rst,
  output logic          req,
  input  logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [DW-1:0] checksum
);

  localparam int LW = (LOAD_N > 0) ? $clog2(LOAD_N + 1) : 1;
  localparam int RW = (RES_N > 0) ? $clog2(RES_N + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CRST  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [LW-1:0] c_LD_LAST  = LW'((LOAD_N > 0) ? LOAD_N - 1 : 0);
  localparam logic [RW-1:0] c_RD_LAST  = RW'((RES_N > 0) ? RES_N - 1 : 0);
  localparam logic [AW-1:0] c_RES_BASE = AW'(RES_BASE);
  localparam logic [CW-1:0] c_CYC_MAX  = '1;

  // Abort fires in the TIMEOUT-th RUN cycle; clamp so a saturated counter still aborts.
  localparam logic [63:0] c_CMAX_W  = (64'd1 << CW) - 64'd1;
  localparam logic [63:0] c_TO_W    = (TIMEOUT < 1) ? 64'd0 : 64'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_TO_LAST = CW'((c_TO_W > c_CMAX_W) ? c_CMAX_W : c_TO_W);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [LW-1:0] r_ld_cnt;
  logic [RW-1:0] r_rd_cnt;
  logic [CW-1:0] r_cycles;
  logic          r_timeout;

  logic          w_start_acc;
  logic          w_ld_hs;
  logic          w_dr_hs;
  logic          w_ld_last;
  logic          w_rd_last;
  logic          w_to_hit;
  logic [AW-1:0] w_ld_addr;
  logic [AW-1:0] w_rd_addr;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_ld_hs     = (r_state == S_LOAD) && in_valid;
  assign w_dr_hs     = (r_state == S_DRAIN) && out_ready;
  assign w_ld_last   = (r_ld_cnt == c_LD_LAST);
  assign w_rd_last   = (r_rd_cnt == c_RD_LAST);
  assign w_to_hit    = (r_cycles == c_TO_LAST);
  assign w_ld_addr   = AW'(r_ld_cnt);
  assign w_rd_addr   = c_RES_BASE + AW'(r_rd_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (LOAD_N > 0) ? S_LOAD : S_CRST;
        end
      end
      S_LOAD: begin
        if (in_valid && w_ld_last) begin
          w_next = S_CRST;
        end
      end
      S_CRST: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        // A completion seen in the same cycle as the timeout takes precedence.
        if (done) begin
          w_next = (RES_N > 0) ? S_DRAIN : S_IDLE;
        end else if (w_to_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (out_ready && w_rd_last) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    in_ready   = 1'b0;
    mem_own    = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    core_rst   = 1'b0;
    req        = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        mem_own  = 1'b1;
        mem_addr = w_ld_addr;
        if (in_valid) begin
          mem_wr_en  = 1'b1;
          mem_wr_dat = in_data;
        end
      end
      S_CRST: begin
        core_rst = 1'b1;
      end
      S_RUN: begin
        req = 1'b1;
      end
      S_DRAIN: begin
        mem_own   = 1'b1;
        mem_addr  = w_rd_addr;
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Kept apart from the output process: mem_rd_dat is a combinational function of mem_addr.
  assign out_data = (r_state == S_DRAIN) ? mem_rd_dat : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else if (w_start_acc) begin
      r_ld_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_ld_hs) begin
        r_ld_cnt <= r_ld_cnt + 1'b1;
      end
      if (w_dr_hs) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (r_state == S_RUN) begin
        if (r_cycles != c_CYC_MAX) begin
          r_cycles <= r_cycles + 1'b1;
        end
        if (!done && w_to_hit) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign cycles  = r_cycles;
  assign timeout = r_timeout;

`ifdef HOST_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_dr_hs) begin
      r_checksum <= r_checksum + mem_rd_dat;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_host_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_core_host_seq : directed + randomized jobs against a queue-based model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_core_host_seq;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int LOAD_N   = 4;
  localparam int RES_BASE = 8;
  localparam int RES_N    = 2;
  localparam int TIMEOUT  = 16;
  localparam int CW       = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          done = 1'b0;
  logic          in_ready;
  logic          mem_own;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_dat;
  logic [DW-1:0] mem_rd_dat;
  logic          core_rst;
  logic          req;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [DW-1:0] checksum;

  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdat = '0;
  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared data memory: host port when mem_own, otherwise the behavioural core.
  always @(posedge clk) begin
    if (mem_own && mem_wr_en) mem[mem_addr] <= mem_wr_dat;
    else if (!mem_own && core_we) mem[core_addr] <= core_wdat;
  end
  assign mem_rd_dat = mem[mem_addr];

  core_host_seq #(
    .AW(AW), .DW(DW), .LOAD_N(LOAD_N), .RES_BASE(RES_BASE),
    .RES_N(RES_N), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_dat(mem_wr_dat), .mem_rd_dat(mem_rd_dat),
    .core_rst(core_rst), .req(req), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout(timeout), .cycles(cycles), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_own"}, mem_own, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdat"}, mem_wr_dat, 0);
    chk({tag, "_core_rst"}, core_rst, 0);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // One full job. done_at = RUN cycle in which done is raised (0 = never).
  task automatic run_job(input int done_at, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                         input bit gaps, input bit bp);
    logic [DW-1:0] words[$];
    logic [DW-1:0] res[$];
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    int            k;
    int            it;
    int            stall;
    words = {};
    res   = {r0, r1};
    sum   = '0;
    start = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    tick();
    start = 1'b0;
    chk("start_clr_timeout", timeout, 0);
    chk("start_clr_cycles", cycles, 0);
    chk("start_clr_checksum", checksum, 0);

    k  = 0;
    it = 0;
    while (k < LOAD_N && it < 64) begin
      w        = DW'($urandom);
      in_valid = gaps ? ((it == 1) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      in_data  = w;
      #1;
      chk("ld_busy", busy, 1);
      chk("ld_ready", in_ready, 1);
      chk("ld_own", mem_own, 1);
      chk("ld_wr_en", mem_wr_en, in_valid);
      chk("ld_addr", mem_addr, k);
      if (in_valid) begin
        chk("ld_wdat", mem_wr_dat, w);
        words.push_back(w);
        k++;
      end
      tick();
      it++;
    end
    chk("ld_count", k, LOAD_N);
    in_valid = 1'b0;

    #1;
    chk("crst_pulse", core_rst, 1);
    chk("crst_own", mem_own, 0);
    chk("crst_req", req, 0);
    chk("crst_busy", busy, 1);
    for (int i = 0; i < LOAD_N; i++) chk("ld_mem", mem[i], words[i]);
    tick();

    for (int c = 1; c <= TIMEOUT; c++) begin
      core_we   = (c <= RES_N);
      core_addr = AW'(RES_BASE + c - 1);
      core_wdat = (c <= RES_N) ? res[c-1] : '0;
      done      = (c == done_at);
      start     = 1'($urandom_range(0, 1));
      #1;
      chk("run_req", req, 1);
      chk("run_core_rst", core_rst, 0);
      chk("run_own", mem_own, 0);
      chk("run_wr_en", mem_wr_en, 0);
      chk("run_cycles", cycles, c - 1);
      chk("run_timeout", timeout, 0);
      tick();
      if (c == done_at) break;
    end
    core_we = 1'b0;
    done    = 1'b0;
    start   = 1'b0;

    if (done_at > 0 && done_at <= TIMEOUT) begin
      #1;
      chk("done_cycles", cycles, done_at);
      chk("done_timeout", timeout, 0);
      chk("done_req_fall", req, 0);
      for (int j = 0; j < RES_N; j++) begin
        stall = (bp && j == 0) ? 3 : $urandom_range(0, 1);
        for (int s = 0; s < stall; s++) begin
          out_ready = 1'b0;
          #1;
          chk("dr_hold_valid", out_valid, 1);
          chk("dr_hold_data", out_data, res[j]);
          chk("dr_hold_addr", mem_addr, AW'(RES_BASE + j));
          tick();
        end
        out_ready = 1'b1;
        #1;
        chk("dr_valid", out_valid, 1);
        chk("dr_own", mem_own, 1);
        chk("dr_data", out_data, res[j]);
        sum = sum + res[j];
        tick();
      end
      out_ready = 1'b0;
      #1;
      chk("dr_end_busy", busy, 0);
      chk("dr_end_valid", out_valid, 0);
`ifdef HOST_CHECKSUM_EN
      chk("checksum", checksum, sum);
`else
      chk("checksum", checksum, 0);
`endif
    end else begin
      #1;
      chk("to_flag", timeout, 1);
      chk("to_busy", busy, 0);
      chk("to_out_valid", out_valid, 0);
      chk("to_cycles", cycles, TIMEOUT);
      chk("to_checksum", checksum, 0);
    end
  endtask

  initial begin
    #3;
    chk_quiet("rst");
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_checksum", checksum, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed: gaps in LOAD, done in RUN cycle 10, 3-cycle drain stall.
    run_job(10, 8'hF0, 8'h20, 1'b1, 1'b1);
    tick();

    // Timeout: done never raised; flags must hold through IDLE.
    run_job(0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("to_hold_flag", timeout, 1);
    chk("to_hold_cycles", cycles, TIMEOUT);

    // Asynchronous reset in the middle of a load.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_timeout_clr", timeout, 0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      tick();
    end
    chk("mid_ld_addr", mem_addr, 2);
    reset = 1'b1;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_cycles", cycles, 0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();

    // done and timeout in the same cycle: done takes precedence.
    run_job(TIMEOUT, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
    tick();

    for (int n = 0; n < 3; n++) begin
      run_job($urandom_range(3, 15), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_host_seq.md
Name: core_host_seq

Overview:
- Host-side initiator for the processor core's req/done handshake.
- Preloads operand words into data memory from a valid/ready input stream, then resets and launches the core.
- Waits for done (with timeout), then streams result words back out of data memory.
- Sits between the bench/host and top-level core; owns the data-memory port except while the core runs.

Parameters:
AW, 8, data-memory address width
DW, 8, data word width
LOAD_N, 64, operand words preloaded starting at address 0 (0 = skip load)
RES_BASE, 64, first result address
RES_N, 32, result words drained (0 = skip drain)
TIMEOUT, 4096, max RUN cycles before abort
CW, 16, cycle-counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch job; sampled only in IDLE
in_valid  in  1  operand word valid
in_ready  out  1  operand word accepted when in_valid&&in_ready
in_data  in  DW  operand word
mem_own  out  1  high: host drives data-memory port; low: core drives it
mem_wr_en  out  1  data-memory write strobe
mem_addr  out  AW  data-memory address
mem_wr_dat  out  DW  data-memory write data
mem_rd_dat  in  DW  data-memory read data, combinational from mem_addr
core_rst  out  1  one-cycle reset pulse to core
req  out  1  job request to core
done  in  1  core completion level
out_valid  out  1  result word valid
out_ready  in  1  result consumer ready
out_data  out  DW  result word
busy  out  1  high in any state but IDLE
timeout  out  1  sticky abort flag; cleared on next accepted start
cycles  out  CW  RUN-cycle count of last/current job
checksum  out  DW  see Optional Feature

Behaviour:
- Reset (async, any state) forces IDLE and clears ld_cnt, rd_cnt, cycles, timeout and checksum. All outputs read 0.
- States: IDLE, LOAD, CRST, RUN, DRAIN.
- IDLE:
  - start=1 → LOAD (or CRST if LOAD_N=0).
  - On that transition, clear ld_cnt, rd_cnt, cycles, timeout and checksum.
  - start is ignored in every other state.
- LOAD:
  - mem_own=1, in_ready=1.
  - On a handshake, in the same cycle: mem_wr_en=1, mem_addr=ld_cnt, mem_wr_dat=in_data; ld_cnt increments.
  - After handshake number LOAD_N → CRST.
  - When not handshaking: mem_wr_en=0, mem_addr=ld_cnt.
- CRST:
  - core_rst=1 for exactly one cycle; mem_own=0.
  - Next state is RUN.
- RUN:
  - req=1, mem_own=0, mem_wr_en=0.
  - cycles increments every RUN cycle, saturating at 2^CW-1.
  - done=1 sampled → DRAIN (or IDLE if RES_N=0); req falls on the next cycle.
  - No done after TIMEOUT RUN cycles (cycles==TIMEOUT) → timeout=1, go to IDLE, no drain.
  - If done and timeout occur in the same cycle, done wins.
- DRAIN:
  - mem_own=1, mem_addr=(RES_BASE+rd_cnt) mod 2^AW.
  - out_valid=1, out_data=mem_rd_dat.
  - out_valid is not dropped once raised; out_data is stable while out_ready=0.
  - On out_ready, rd_cnt increments; after RES_N transfers → IDLE.
- Address arithmetic wraps modulo 2^AW. ld_cnt and rd_cnt are wide enough to hold LOAD_N and RES_N.
- cycles and timeout hold their values in IDLE until the next start.

Optional Feature:
- Macro: HOST_CHECKSUM_EN.
- Defined:
  - checksum accumulates (checksum + out_data) mod 2^DW on each DRAIN handshake.
  - It is cleared on start and held in IDLE.
- Undefined:
  - checksum is tied to 0 and the accumulator is not built.

Test Plan:
- LOAD_N=4, RES_N=2, RES_BASE=8: start; stream 0x11,0x22,0x33,0x44 with in_valid continuous → writes to addr 0..3 on consecutive cycles; core_rst pulses once; req rises the cycle after.
- RUN with done asserted after 10 RUN cycles → cycles=10; req drops next cycle; DRAIN presents mem[8], then mem[9]; busy falls after the second out_ready.
- done never asserted, TIMEOUT=16 → after 16 RUN cycles: timeout=1, busy=0, no out_valid; next start clears timeout.
- Backpressure: out_ready low for 3 cycles in DRAIN → out_valid and out_data stable; in_valid gaps in LOAD → no mem_wr_en in the gap cycles.
- Async reset asserted mid-LOAD at ld_cnt=2 → outputs 0 immediately; after release, start restarts the load at addr 0.
- HOST_CHECKSUM_EN defined, results 0xF0 and 0x20 → checksum=0x10. Undefined → checksum=0.
